alu_issue_ctrl: RTL and testbench

- Single-issue sequencer in front of the ALU operand-routing demux and the functional units (add, sub, mul, div, and, or, xor, li).
- Accepts one decoded instruction at a time and drives a registered one-hot unit select plus operands.
- Counts each unit's fixed latency, captures the result and issues a one-cycle register-file writeback.
- Rejects undefined opcodes without issuing them.

---
 rtl/alu_issue_ctrl_pkg.sv | 34 +++
 rtl/alu_issue_ctrl_if.sv | 42 ++++
 rtl/alu_issue_ctrl_decode.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// m_cpu_pkg: shared opcode/state encodings, unit count and default
// latencies for the ALU issue controller slice.
package m_cpu_pkg;

    localparam int unsigned FU_COUNT    = 8;
    localparam int unsigned OPW         = 3;   // bits needed to index a unit
    localparam int unsigned DEF_MUL_LAT = 3;
    localparam int unsigned DEF_DIV_LAT = 8;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_LI  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Width of a down-counter able to hold (max latency - 1).
    function automatic int unsigned lat_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, functional-unit drive and
// register-file writeback bundle. master = instruction source / unit side,
// slave = the issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned N   = 16,
    parameter int unsigned SEL = 4,
    parameter int unsigned RA  = 3
) ();

    logic           instr_valid;
    logic           instr_ready;
    logic [SEL-1:0] op_opcode;
    logic [RA-1:0]  rd_addr;
    logic [N-1:0]   rs1_reg_val;
    logic [N-1:0]   rs2_reg_val;

    logic [7:0]     fu_sel;
    logic           fu_start;
    logic [N-1:0]   fu_rs1;
    logic [N-1:0]   fu_rs2;
    logic [N-1:0]   fu_result;

    logic           wb_en;
    logic [RA-1:0]  wb_addr;
    logic [N-1:0]   wb_data;

    logic           busy;
    logic           illegal_op;

    modport master (
        output instr_valid, op_opcode, rd_addr, rs1_reg_val, rs2_reg_val, fu_result,
        input  instr_ready, fu_sel, fu_start, fu_rs1, fu_rs2,
        input  wb_en, wb_addr, wb_data, busy, illegal_op
    );

    modport slave (
        input  instr_valid, op_opcode, rd_addr, rs1_reg_val, rs2_reg_val, fu_result,
        output instr_ready, fu_sel, fu_start, fu_rs1, fu_rs2,
        output wb_en, wb_addr, wb_data, busy, illegal_op
    );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: purely combinational opcode decode -- one-hot unit
// select, legality flag, latency-minus-one and li detection.
module alu_op_decode
    import m_cpu_pkg::*;
#(
    parameter int unsigned SEL     = 4,
    parameter int unsigned LW      = 3,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic [SEL-1:0]      opcode,
    output logic [FU_COUNT-1:0] sel,
    output logic                legal,
    output logic [LW-1:0]       lat_m1,
    output logic                is_li
);

    op_e op;

    assign op = op_e'(opcode[OPW-1:0]);

    // Map opcode to unit select and latency; undefined opcodes select nothing.
    always_comb begin
        sel    = '0;
        legal  = (32'(opcode) < FU_COUNT);
        lat_m1 = '0;
        is_li  = 1'b0;
        if (legal) begin
            sel[op] = 1'b1;
            case (op)
                OP_MUL:  lat_m1 = LW'(MUL_LAT - 1);
                OP_DIV:  lat_m1 = LW'(DIV_LAT - 1);
                OP_LI:   is_li  = 1'b1;
                default: lat_m1 = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue sequencer IDLE -> EXEC -> WB in front of the
// ALU functional units. Drives a registered one-hot unit select, held
// operands and a one-cycle start, counts the unit latency, then emits a
// one-cycle writeback. Undefined opcodes are accepted and flagged only.
// Optional build macro ALU_ISSUE_PERF_EN adds perf_issued, perf_illegal and
// perf_busy_cyc counters.
module alu_issue_ctrl
    import m_cpu_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned SEL     = 4,
    parameter int unsigned RA      = 3,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [15:0]       perf_illegal,
    output logic [31:0]       perf_busy_cyc
`endif
);

    localparam int unsigned LW = lat_width(MUL_LAT, DIV_LAT);

    state_e              state;
    logic [FU_COUNT-1:0] fu_sel_q;
    logic                fu_start_q;
    logic [N-1:0]        rs1_q;
    logic [N-1:0]        rs2_q;
    logic [RA-1:0]       rd_q;
    logic                li_q;
    logic [LW-1:0]       cnt_q;
    logic                wb_en_q;
    logic [RA-1:0]       wb_addr_q;
    logic [N-1:0]        wb_data_q;
    logic                illegal_q;

    logic [FU_COUNT-1:0] dec_sel;
    logic                dec_legal;
    logic [LW-1:0]       dec_lat;
    logic                dec_li;
    logic                ready;
    logic                accept;

    alu_op_decode #(
        .SEL     (SEL),
        .LW      (LW),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_decode (
        .opcode (bus.op_opcode),
        .sel    (dec_sel),
        .legal  (dec_legal),
        .lat_m1 (dec_lat),
        .is_li  (dec_li)
    );

    assign ready  = (state == IDLE) || (state == WB);
    assign accept = bus.instr_valid && ready;

    assign bus.instr_ready = ready;
    assign bus.busy        = (state != IDLE);
    assign bus.fu_sel      = fu_sel_q;
    assign bus.fu_start    = fu_start_q;
    assign bus.fu_rs1      = rs1_q;
    assign bus.fu_rs2      = rs2_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.illegal_op  = illegal_q;

    // Issue FSM: accept in IDLE/WB, count latency in EXEC, writeback on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fu_sel_q   <= '0;
            fu_start_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            li_q       <= 1'b0;
            cnt_q      <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            fu_start_q <= 1'b0;
            wb_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            case (state)
                IDLE, WB: begin
                    state    <= IDLE;
                    fu_sel_q <= '0;
                    if (accept) begin
                        if (dec_legal) begin
                            state      <= EXEC;
                            fu_sel_q   <= dec_sel;
                            fu_start_q <= 1'b1;
                            rs1_q      <= bus.rs1_reg_val;
                            rs2_q      <= bus.rs2_reg_val;
                            rd_q       <= bus.rd_addr;
                            li_q       <= dec_li;
                            cnt_q      <= dec_lat;
                        end else begin
                            illegal_q  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state     <= WB;
                        fu_sel_q  <= '0;
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= rd_q;
                        wb_data_q <= li_q ? rs2_q : bus.fu_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued   <= '0;
            perf_illegal  <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (fu_start_q)
                perf_issued <= perf_issued + 32'd1;
            if (accept && !dec_legal)
                perf_illegal <= perf_illegal + 16'd1;
            if (state != IDLE)
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors with hand-computed expectations for
// alu_issue_ctrl (MUL_LAT=3, DIV_LAT=8).
module tb_alu_issue_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_issue_ctrl_if #(.N(16), .SEL(4), .RA(3)) bus ();

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [15:0] perf_illegal;
    logic [31:0] perf_busy_cyc;
`endif

    alu_issue_ctrl #(
        .N       (16),
        .SEL     (4),
        .RA      (3),
        .MUL_LAT (3),
        .DIV_LAT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued   (perf_issued),
        .perf_illegal  (perf_illegal),
        .perf_busy_cyc (perf_busy_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [2:0] rd,
                         input logic [15:0] a, input logic [15:0] b);
        bus.instr_valid = 1'b1;
        bus.op_opcode   = op;
        bus.rd_addr     = rd;
        bus.rs1_reg_val = a;
        bus.rs2_reg_val = b;
    endtask

    initial begin
        int wb_seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.op_opcode   = '0;
        bus.rd_addr     = '0;
        bus.rs1_reg_val = '0;
        bus.rs2_reg_val = '0;
        bus.fu_result   = '0;

        // reset state
        step();
        step();
        chk("rst_fu_sel",  32'(bus.fu_sel), 32'h0);
        chk("rst_wb_en",   32'(bus.wb_en), 32'h0);
        chk("rst_busy",    32'(bus.busy), 32'h0);
        chk("rst_ready",   32'(bus.instr_ready), 32'h1);
        chk("rst_illegal", 32'(bus.illegal_op), 32'h0);
        #2 rst = 1'b0;

        // add: rd=3 rs1=5 rs2=7 result=12
        step();
        offer(4'd0, 3'd3, 16'd5, 16'd7);
        bus.fu_result = 16'd12;
        step();
        bus.instr_valid = 1'b0;
        chk("add_sel",    32'(bus.fu_sel), 32'h01);
        chk("add_start",  32'(bus.fu_start), 32'h1);
        chk("add_rs1",    32'(bus.fu_rs1), 32'd5);
        chk("add_rs2",    32'(bus.fu_rs2), 32'd7);
        chk("add_ready1", 32'(bus.instr_ready), 32'h0);
        chk("add_wb_t1",  32'(bus.wb_en), 32'h0);
        step();
        chk("add_wb_en",   32'(bus.wb_en), 32'h1);
        chk("add_wb_addr", 32'(bus.wb_addr), 32'd3);
        chk("add_wb_data", 32'(bus.wb_data), 32'd12);
        chk("add_start2",  32'(bus.fu_start), 32'h0);
        chk("add_sel_wb",  32'(bus.fu_sel), 32'h0);
        chk("add_ready2",  32'(bus.instr_ready), 32'h1);
        step();
        chk("add_wb_off",  32'(bus.wb_en), 32'h0);
        chk("add_idle",    32'(bus.busy), 32'h0);
        chk("add_hold",    32'(bus.wb_data), 32'd12);

        // mul: rd=1 result=35, wb at T+4
        offer(4'd2, 3'd1, 16'd5, 16'd7);
        bus.fu_result = 16'd35;
        step();
        bus.instr_valid = 1'b0;
        chk("mul_sel",   32'(bus.fu_sel), 32'h04);
        chk("mul_start", 32'(bus.fu_start), 32'h1);
        chk("mul_busy1", 32'(bus.busy), 32'h1);
        chk("mul_rdy1",  32'(bus.instr_ready), 32'h0);
        step();
        chk("mul_start2", 32'(bus.fu_start), 32'h0);
        chk("mul_sel2",   32'(bus.fu_sel), 32'h04);
        chk("mul_wb2",    32'(bus.wb_en), 32'h0);
        chk("mul_rdy2",   32'(bus.instr_ready), 32'h0);
        step();
        chk("mul_wb3",    32'(bus.wb_en), 32'h0);
        chk("mul_busy3",  32'(bus.busy), 32'h1);
        step();
        chk("mul_wb4",    32'(bus.wb_en), 32'h1);
        chk("mul_addr",   32'(bus.wb_addr), 32'd1);
        chk("mul_data",   32'(bus.wb_data), 32'd35);
        chk("mul_busy4",  32'(bus.busy), 32'h1);
        step();
        chk("mul_busy5",  32'(bus.busy), 32'h0);
        chk("mul_wb5",    32'(bus.wb_en), 32'h0);

        // li then back-to-back add offered in the WB cycle
        offer(4'd7, 3'd5, 16'd0, 16'hBEEF);
        bus.fu_result = 16'd0;
        step();
        bus.instr_valid = 1'b0;
        chk("li_sel", 32'(bus.fu_sel), 32'h80);
        step();
        chk("li_wb_en",   32'(bus.wb_en), 32'h1);
        chk("li_wb_data", 32'(bus.wb_data), 32'hBEEF);
        chk("li_wb_addr", 32'(bus.wb_addr), 32'd5);
        chk("li_ready",   32'(bus.instr_ready), 32'h1);
        offer(4'd0, 3'd2, 16'd10, 16'd20);
        bus.fu_result = 16'd30;
        step();
        bus.instr_valid = 1'b0;
        chk("b2b_start", 32'(bus.fu_start), 32'h1);
        chk("b2b_sel",   32'(bus.fu_sel), 32'h01);
        chk("b2b_rs1",   32'(bus.fu_rs1), 32'd10);
        chk("b2b_busy",  32'(bus.busy), 32'h1);
        step();
        chk("b2b_wb_en",   32'(bus.wb_en), 32'h1);
        chk("b2b_wb_data", 32'(bus.wb_data), 32'd30);
        chk("b2b_wb_addr", 32'(bus.wb_addr), 32'd2);
        step();

        // illegal opcode 9
        offer(4'd9, 3'd4, 16'd1, 16'd2);
        step();
        bus.instr_valid = 1'b0;
        chk("ill_pulse", 32'(bus.illegal_op), 32'h1);
        chk("ill_start", 32'(bus.fu_start), 32'h0);
        chk("ill_busy",  32'(bus.busy), 32'h0);
        chk("ill_sel",   32'(bus.fu_sel), 32'h0);
        chk("ill_rdy",   32'(bus.instr_ready), 32'h1);
        step();
        chk("ill_pulse_off", 32'(bus.illegal_op), 32'h0);
        chk("ill_wb",        32'(bus.wb_en), 32'h0);
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_illegal",  32'(perf_illegal), 32'd1);
        chk("perf_issued",   perf_issued, 32'd4);
        chk("perf_busy_cyc", perf_busy_cyc, 32'd10);
`endif

        // div with valid held: second op accepted only in WB (T+9)
        offer(4'd3, 3'd6, 16'd100, 16'd7);
        bus.fu_result = 16'd14;
        step();
        chk("div_start", 32'(bus.fu_start), 32'h1);
        offer(4'd0, 3'd7, 16'h1000, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            chk("div_rdy",  32'(bus.instr_ready), 32'h0);
            chk("div_sel",  32'(bus.fu_sel), 32'h08);
            chk("div_rs1",  32'(bus.fu_rs1), 32'd100);
            chk("div_wb",   32'(bus.wb_en), 32'h0);
            bus.rs1_reg_val = 16'h1000 + 16'(k);
            step();
        end
        chk("div_wb_en",   32'(bus.wb_en), 32'h1);
        chk("div_wb_data", 32'(bus.wb_data), 32'd14);
        chk("div_wb_addr", 32'(bus.wb_addr), 32'd6);
        chk("div_rdy_wb",  32'(bus.instr_ready), 32'h1);
        bus.rs1_reg_val = 16'h2222;
        bus.fu_result   = 16'd3;
        step();
        bus.instr_valid = 1'b0;
        chk("div2_start", 32'(bus.fu_start), 32'h1);
        chk("div2_sel",   32'(bus.fu_sel), 32'h01);
        chk("div2_rs1",   32'(bus.fu_rs1), 32'h2222);
        chk("div2_rs2",   32'(bus.fu_rs2), 32'd2);
        step();
        chk("div2_wb_en",   32'(bus.wb_en), 32'h1);
        chk("div2_wb_data", 32'(bus.wb_data), 32'd3);
        chk("div2_wb_addr", 32'(bus.wb_addr), 32'd7);
        step();

        // reset in the middle of a div
        offer(4'd3, 3'd2, 16'd50, 16'd60);
        bus.fu_result = 16'd77;
        step();
        bus.instr_valid = 1'b0;
        step();
        step();
        chk("mid_busy_pre", 32'(bus.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_sel",     32'(bus.fu_sel), 32'h0);
        chk("mid_busy",    32'(bus.busy), 32'h0);
        chk("mid_rs1",     32'(bus.fu_rs1), 32'h0);
        chk("mid_rs2",     32'(bus.fu_rs2), 32'h0);
        chk("mid_wb_data", 32'(bus.wb_data), 32'h0);
        chk("mid_wb_addr", 32'(bus.wb_addr), 32'h0);
        chk("mid_ready",   32'(bus.instr_ready), 32'h1);
        @(posedge clk);
        #3 rst = 1'b0;
        wb_seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.wb_en === 1'b1) wb_seen++;
        end
        chk("mid_no_wb",   32'(wb_seen), 32'd0);
        chk("mid_ready2",  32'(bus.instr_ready), 32'h1);
        chk("mid_idle",    32'(bus.busy), 32'h0);
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_rst_issued", perf_issued, 32'd0);
        chk("perf_rst_ill",    32'(perf_illegal), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
